// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module      : video_timing_pkg
// Description : Shared 640x480@60 raster constants and coordinate type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int SCREEN_W = H_ACTIVE;
    localparam int SCREEN_H = V_ACTIVE;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/sync_axis_counter.sv
// ============================================================================
// Module      : sync_axis_counter
// Description : Wrapping raster axis counter with terminal count and
//               active/sync decode of the position it will present next.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   advance,
    output coord_t count,
    output logic   last,
    output logic   next_active,
    output logic   next_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    generate
        if (TOTAL > (1 << COORD_W)) begin : g_total_check
            $error("sync_axis_counter: total period exceeds coordinate range");
        end
    endgenerate

    coord_t next_count;

    assign last       = (count == COORD_W'(TOTAL - 1));
    assign next_count = advance ? (last ? '0 : count + COORD_W'(1)) : count;

    // Decodes look at the value being loaded so flags register alongside it.
    assign next_active = int'(next_count) < ACTIVE;
    assign next_sync   = (int'(next_count) >= ACTIVE + FP) &&
                         (int'(next_count) <  ACTIVE + FP + SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (advance) begin
            count <= next_count;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing source: pixel coordinates, sync pins and
//               line/frame markers, all registered with zero skew.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       active_video,
    output logic       h_sync,
    output logic       v_sync,
    output logic       v_sync_pulse,
    output logic       line_start,
    output logic       frame_start
);

    import video_timing_pkg::*;

    logic running;
    logic h_adv;
    logic v_adv;
    logic h_last;
    logic v_last;
    logic h_next_active;
    logic v_next_active;
    logic h_next_sync;
    logic v_next_sync;

    // Counters stay parked at (0,0) until the first enabled edge.
    assign h_adv = en & running;
    assign v_adv = h_adv & h_last;

    sync_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk         (pixel_clk),
        .rst         (rst),
        .advance     (h_adv),
        .count       (sx),
        .last        (h_last),
        .next_active (h_next_active),
        .next_sync   (h_next_sync)
    );

    sync_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk         (pixel_clk),
        .rst         (rst),
        .advance     (v_adv),
        .count       (sy),
        .last        (v_last),
        .next_active (v_next_active),
        .next_sync   (v_next_sync)
    );

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            running      <= 1'b0;
            active_video <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            v_sync_pulse <= 1'b0;
            h_sync       <= ~H_POL;
            v_sync       <= ~V_POL;
        end else if (en) begin
            running      <= 1'b1;
            active_video <= h_next_active & v_next_active;
            line_start   <= ~running | h_last;
            frame_start  <= ~running | (h_last & v_last);
            v_sync_pulse <= v_next_sync;
            h_sync       <= h_next_sync ? H_POL : ~H_POL;
            v_sync       <= v_next_sync ? V_POL : ~V_POL;
        end else begin
            // Stalled: position and sync levels hold, markers drop.
            active_video <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen (default geometry
//               and a small inverted-polarity geometry side by side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;

    localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;

    logic       pixel_clk = 1'b0;
    logic       rst;
    logic       en;

    logic [9:0] a_sx, a_sy, b_sx, b_sy;
    logic       a_av, a_hs, a_vs, a_vsp, a_ls, a_fs;
    logic       b_av, b_hs, b_vs, b_vsp, b_ls, b_fs;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_gen dut_a (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .en           (en),
        .sx           (a_sx),
        .sy           (a_sy),
        .active_video (a_av),
        .h_sync       (a_hs),
        .v_sync       (a_vs),
        .v_sync_pulse (a_vsp),
        .line_start   (a_ls),
        .frame_start  (a_fs)
    );

    video_timing_gen #(
        .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
        .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
        .H_POL    (1'b1), .V_POL (1'b1)
    ) dut_b (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .en           (en),
        .sx           (b_sx),
        .sy           (b_sy),
        .active_video (b_av),
        .h_sync       (b_hs),
        .v_sync       (b_vs),
        .v_sync_pulse (b_vsp),
        .line_start   (b_ls),
        .frame_start  (b_fs)
    );

    // Reference model: raster position as plain integers.
    int running, en_last, ax, ay, bx, by;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit rst;
        bit en;
        int sx;
        int sy;
        bit av;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        running = 0;
        en_last = 0;
        ax = 0; ay = 0; bx = 0; by = 0;
    endtask

    task automatic advance(inout int x, inout int y, input int ht, input int vt);
        x = x + 1;
        if (x == ht) begin
            x = 0;
            y = (y + 1) % vt;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (en && running != 0) begin
                advance(ax, ay, AHT, AVT);
                advance(bx, by, BHT, BVT);
            end
            if (en) running = 1;
            en_last = int'(en);
        end
    endtask

    task automatic check_axis(input string tag, input int x, input int y,
                              input int ha, input int hf, input int hs,
                              input int va, input int vf, input int vs,
                              input bit hp, input bit vp,
                              input logic [9:0] sx, input logic [9:0] sy,
                              input logic av, input logic hsync, input logic vsync,
                              input logic vsp, input logic ls, input logic fs);
        bit in_h, in_v, live;
        in_h = (x >= ha + hf) && (x < ha + hf + hs);
        in_v = (y >= va + vf) && (y < va + vf + vs);
        live = (en_last != 0);
        chk({tag, ".sx"},           32'(sx),    x);
        chk({tag, ".sy"},           32'(sy),    y);
        chk({tag, ".active_video"}, 32'(av),    int'(live && x < ha && y < va));
        chk({tag, ".line_start"},   32'(ls),    int'(live && x == 0));
        chk({tag, ".frame_start"},  32'(fs),    int'(live && x == 0 && y == 0));
        chk({tag, ".h_sync"},       32'(hsync), int'(in_h ? hp : !hp));
        chk({tag, ".v_sync"},       32'(vsync), int'(in_v ? vp : !vp));
        chk({tag, ".v_sync_pulse"}, 32'(vsp),   int'(in_v));
    endtask

    task automatic check_all();
        check_axis("A", ax, ay, AHA, AHF, AHS, AVA, AVF, AVS, 1'b0, 1'b0,
                   a_sx, a_sy, a_av, a_hs, a_vs, a_vsp, a_ls, a_fs);
        check_axis("B", bx, by, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1, 1'b1,
                   b_sx, b_sy, b_av, b_hs, b_vs, b_vsp, b_ls, b_fs);
    endtask

    task automatic step();
        @(posedge pixel_clk);
        model_edge();
        @(negedge pixel_clk);
    endtask

    initial begin
        int cnt, rises, frames, seen;
        logic prev_vsp;

        tbl[0] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check_all();

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            step();
            chk($sformatf("vec%0d.sx", i),  32'(a_sx), tbl[i].sx);
            chk($sformatf("vec%0d.sy", i),  32'(a_sy), tbl[i].sy);
            chk($sformatf("vec%0d.av", i),  32'(a_av), int'(tbl[i].av));
            chk($sformatf("vec%0d.ls", i),  32'(a_ls), int'(tbl[i].ls));
            chk($sformatf("vec%0d.fs", i),  32'(a_fs), int'(tbl[i].fs));
        end

        // Free-run to (100,10), checking every cycle including line wraps.
        en = 1'b1;
        for (int c = 0; c < 20000 && !(ax == 100 && ay == 10); c++) begin
            step();
            check_all();
        end
        chk("reach.sx", 32'(a_sx), 100);
        chk("reach.sy", 32'(a_sy), 10);

        en = 1'b0;
        repeat (37) begin
            step();
            check_all();
        end
        chk("hold.sx", 32'(a_sx), 100);
        chk("hold.sy", 32'(a_sy), 10);
        chk("hold.av", 32'(a_av), 0);

        en = 1'b1;
        step();
        chk("resume.sx", 32'(a_sx), 101);
        chk("resume.sy", 32'(a_sy), 10);
        chk("resume.av", 32'(a_av), 1);
        check_all();

        // Random enable pattern; small geometry completes many frames.
        cnt = 0; rises = 0; frames = 0; seen = 0;
        prev_vsp = b_vsp;
        for (int c = 0; c < 15000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            step();
            check_all();
            if (en) cnt++;
            if (b_vsp && !prev_vsp) begin
                rises++;
                chk("B.vsp_rise_sx", 32'(b_sx), 0);
                chk("B.vsp_rise_sy", 32'(b_sy), BVA + BVF);
            end
            prev_vsp = b_vsp;
            if (b_fs) begin
                if (seen != 0) begin
                    chk("B.frame_len", 32'(cnt), BHT * BVT);
                    chk("B.vsp_rises", 32'(rises), 1);
                    frames++;
                end
                seen = 1;
                cnt = 0;
                rises = 0;
            end
        end
        chk("B.frames_seen", 32'(frames > 10), 1);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("areset.A.sx", 32'(a_sx), 0);
        chk("areset.A.sy", 32'(a_sy), 0);
        chk("areset.A.hs", 32'(a_hs), 1);
        chk("areset.A.vs", 32'(a_vs), 1);
        chk("areset.B.sx", 32'(b_sx), 0);
        chk("areset.B.sy", 32'(b_sy), 0);
        chk("areset.B.hs", 32'(b_hs), 0);
        chk("areset.B.vs", 32'(b_vs), 0);
        model_reset();
        check_all();
        @(negedge pixel_clk);
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk("restart.A.fs", 32'(a_fs), 1);
        chk("restart.B.fs", 32'(b_fs), 1);
        check_all();
        repeat (300) begin
            step();
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source for the HDMI/VGA display path. Drives the `sx`, `sy`, `active_video` and `v_sync_pulse` interface that the game and pattern renderers consume.
- Produces the physical h/v sync pins and frame/line markers.
- Default timing is 640x480@60 (25.175 MHz `pixel_clk`). All timing fields are parameterised.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, physical h_sync level when asserted (0 = active-low)
- V_POL, 0, physical v_sync level when asserted (0 = active-low)

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- en  in  1  timing advance enable (tie 1 for free-running)
- sx  out  10  current horizontal count, 0..H_TOTAL-1
- sy  out  10  current vertical count, 0..V_TOTAL-1
- active_video  out  1  high when sx<H_ACTIVE and sy<V_ACTIVE
- h_sync  out  1  physical hsync, polarity H_POL
- v_sync  out  1  physical vsync, polarity V_POL
- v_sync_pulse  out  1  logical vsync, active-high regardless of V_POL
- line_start  out  1  one-cycle pulse when sx==0
- frame_start  out  1  one-cycle pulse when sx==0 and sy==0

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤1024; elaboration fails otherwise.
- Clock and reset: one clock, `pixel_clk`. Reset `rst` is asynchronous and active-high.
- Reset values: sx=0, sy=0, active_video=0, line_start=0, frame_start=0, v_sync_pulse=0, h_sync=~H_POL, v_sync=~V_POL.
- State: one `running` flag plus the h/v counters.
  - IDLE (entered on reset): outputs hold reset values.
  - First `pixel_clk` edge with en=1 after reset release → RUN. On that edge the outputs present (0,0) with active_video=1, line_start=1, frame_start=1.
- RUN, per edge with en=1:
  - sx increments.
  - When sx==H_TOTAL-1, sx wraps to 0 and sy increments.
  - When sy==V_TOTAL-1 and sx==H_TOTAL-1, both wrap to 0.
- Output alignment: all outputs are registers. Every flag corresponds to the (sx,sy) presented in the same cycle, i.e. zero skew between coordinates and flags. No combinational path from the counters to the ports.
- h_sync asserted iff H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- v_sync and v_sync_pulse asserted iff V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC (default lines 490..491), for the whole line including the wrap to the next line.
- en=0 in RUN:
  - Counters, h_sync, v_sync and v_sync_pulse hold.
  - active_video, line_start and frame_start are forced 0.
  - On en returning to 1, counting resumes from the held position. The markers re-fire only when their condition is met on an advance edge.
- Reset mid-frame: asynchronous return to IDLE and reset values. The next frame starts at (0,0) with frame_start.
- Frame length: exactly H_TOTAL*V_TOTAL enabled cycles between consecutive frame_start pulses (default 420000).
- Rising edge of v_sync_pulse: occurs once per frame, at (0,490). Consumers use it as their physics tick.

Decomposition:
- Package `video_timing_pkg` holds:
  - the 640x480@60 timing constants (H_*/V_*, H_TOTAL, V_TOTAL, SCREEN_W/SCREEN_H);
  - the 10-bit coordinate width.
- The package is shared with the renderers so that screen bounds have one source.
- Sub-module `sync_axis_counter` is a natural split: a generic wrap counter with terminal-count output and sync-window decode.
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Instantiated twice: horizontal, advanced by en; vertical, advanced by the horizontal terminal count.

Test Plan:
1. Reset then en=1 → first edge gives sx=0, sy=0, active_video=1, frame_start=1, line_start=1. Next frame_start arrives exactly 420000 cycles later.
2. Scan one line → active_video high for sx 0..639 and low for 640..799. h_sync low for sx 656..751 only. sx wraps 799→0 with sy+1 and line_start=1.
3. Scan one frame → v_sync low and v_sync_pulse high for sy 490..491 (1600 cycles). Exactly one rising edge of v_sync_pulse per frame. active_video is never high for sy ≥480.
4. Deassert en for 37 cycles at (100,10) → sx/sy hold at (100,10) and active_video=0. After re-enable, the next cycle shows sx=101, sy=10, active_video=1.
5. Assert rst at (700,300) → all outputs take reset values immediately, without waiting for a clock edge. After release, sequence restarts at (0,0) with frame_start=1.
6. Params H_POL=1, V_POL=1 → h_sync/v_sync are high inside their windows. v_sync_pulse is unchanged (active-high).
